load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
// - Initiator side of the data_memory port: turns RV32I load/store requests from the execute stage into word accesses.
// - data_memory is word-addressed, has a single write enable, and a registered read.
// - Handles byte/half/word alignment, load sign/zero extension, and read-modify-write for SB/SH.
// - Sits between the execute stage and data_memory. The core stalls while ready_o=0.
// PARAMETERS
// - DATA_WIDTH  32 (pkg_config)  data word width.
// - ADDR_WIDTH  10               data_memory word-address width (1024 words).
// PORTS
// - clk_i       in   1            clock; all state updates on posedge.
// - rst_ni      in   1            asynchronous, active-low reset.
// - req_i       in   1            access request; accepted when req_i && ready_o.
// - we_i        in   1            1 = store, 0 = load.
// - funct3_i    in   3            RV32I width/sign code.
// - addr_i      in   32           byte address.
// - wdata_i     in   DATA_WIDTH   store data, right-aligned.
// - ready_o     out  1            unit idle; can accept a request.
// - done_o      out  1            one-cycle completion pulse.
// - err_o       out  1            misaligned access; valid with done_o.
// - rdata_o     out  DATA_WIDTH   extended load result; held until the next load completes.
// - mem_we_o    out  1            data_memory write enable.
// - mem_addr_o  out  ADDR_WIDTH   word address = addr[ADDR_WIDTH+1:2]; upper bits ignored, so addresses wrap.
// - mem_data_o  out  DATA_WIDTH   data_memory write data.
// - mem_data_i  in   DATA_WIDTH   data_memory read data; valid one cycle after mem_addr_o is sampled.
// BEHAVIOUR
// - Reset: state IDLE, ready_o=1, done_o=0, err_o=0, rdata_o=0, mem_we_o=0, mem_addr_o=0, mem_data_o=0.
// - Reset mid-access aborts the access immediately. A pending RMW write is dropped; no partial write.
// - Acceptance: request fields are registered on the accepting edge. req_i is ignored while ready_o=0.
// - FSM IDLE -> RD: taken for a load, SB, or SH. mem_addr_o is driven.
// - FSM IDLE -> WR: taken for SW. mem_we_o=1 and mem_data_o=wdata for exactly one cycle.
// - FSM IDLE -> RESP: taken on error. No memory access; err_o=1.
// - FSM RD -> RESP: load. rdata_o is captured from mem_data_i, extended per funct3 and addr[1:0].
// - FSM RD -> MERGE: SB/SH. mem_we_o=1 for one cycle with the old word and the new lane replaced. Other lanes are unchanged.
// - FSM WR/MERGE -> RESP.
// - FSM RESP: done_o=1 for one cycle -> IDLE. A new request can be accepted the cycle after RESP.
// - Latency (accept edge -> done_o high): load 2, SW 2, SB/SH 3, error 1.
// - funct3 decode: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU.
// - Any other funct3 code (and any 1xx code on a store) is treated as word width.
// - Lane select: byte lane = addr[1:0]; half lane = addr[1]. Little-endian.
// - LB/LH sign-extend; LBU/LHU zero-extend.
// - err_o is 0 on every non-error completion. rdata_o is unchanged by stores and errors.
// CONFIGURATION
// - MISALIGN_TRAP_EN defined: half access with addr[0]=1, or word access with addr[1:0]!=0, is an error.
//   - Takes the IDLE -> RESP path: done_o=1, err_o=1, no mem_we_o, rdata_o unchanged.
// - MISALIGN_TRAP_EN undefined: err_o is tied 0.
//   - Misaligned addresses are aligned down: half to addr[1]:0, word to 00. The access proceeds normally.
// TESTING
// - Bench uses a data_memory model with registered read. Preload word0=0x0000_0000, word1=0x8081_82F3, word2=0x0000_0001.
// - LW addr 0x8 -> done_o 2 cycles after accept; rdata_o=0x0000_0001; mem_we_o never 1.
// - LB addr 0x4 -> rdata_o=0xFFFF_FFF3. LBU addr 0x7 -> 0x0000_0080. LH addr 0x6 -> 0xFFFF_8081.
// - SB addr 0x5, wdata 0x0000_00AA -> single mem_we_o pulse writing 0x8081_AAF3 to word1; done_o 3 cycles after accept.
// - SW addr 0x0, wdata 0x1 -> word0=0x0000_0001 after 1 write cycle. A second req_i held during busy is not accepted until ready_o=1.
// - LW addr 0x6: with MISALIGN_TRAP_EN, done_o+err_o 1 cycle after accept, no memory access. Without it, reads word1=0x8081_82F3, err_o=0.
// - rst_ni low during MERGE of SH addr 0x4 -> word1 unchanged, ready_o=1 after release, all outputs at reset values.

Source files
------------

// File: rtl/load_store_unit.sv
// load_store_unit
//   Initiator side of the word-addressed data_memory port. Converts RV32I
//   load/store requests into word accesses. It handles byte/half/word lanes,
//   load sign/zero extension, and read-modify-write for SB/SH.
//
//   Build option: MISALIGN_TRAP_EN
//     defined   -> misaligned half/word accesses complete with err_o=1 and
//                  make no memory write.
//     undefined -> err_o is tied 0 and misaligned addresses are aligned down.
//
//   State table
//     IDLE  | ready for a request; address passes straight through to memory
//     RD    | memory read data valid; load captured or SB/SH merge word built
//     WR    | SW write cycle
//     MERGE | SB/SH write of merged word
//     RESP  | done_o pulse (err_o for trapped accesses)
//
//   Ports
//     clk_i, rst_ni                 clock, async active-low reset
//     req_i, we_i, funct3_i,
//     addr_i, wdata_i               request from execute stage
//     ready_o, done_o, err_o,
//     rdata_o                       handshake / completion / load result
//     mem_we_o, mem_addr_o,
//     mem_data_o, mem_data_i        data_memory port (registered read)
module load_store_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  req_i,
    input  logic                  we_i,
    input  logic [2:0]            funct3_i,
    input  logic [31:0]           addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic                  ready_o,
    output logic                  done_o,
    output logic                  err_o,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_data_o,
    input  logic [DATA_WIDTH-1:0] mem_data_i
);

    typedef enum logic [2:0] {S_IDLE, S_RD, S_WR, S_MERGE, S_RESP} state_t;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    state_t                r_state, w_next;
    logic                  r_we, r_uns;
    logic [1:0]            r_size, r_off;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata, r_rdata;

    logic                  w_accept, w_uns, w_misalign;
    logic [1:0]            w_size, w_off;
    logic [4:0]            w_sh;
    logic [DATA_WIDTH-1:0] w_lane, w_load, w_mask, w_merged;
    logic                  w_unused;

    // Address bits above the memory window are ignored, so accesses wrap.
    assign w_unused = &{1'b0, addr_i[31:ADDR_WIDTH+2]};

    assign w_accept = req_i && (r_state == S_IDLE);

    // Stores only know 000/001 as narrow; every other store code is word.
    always_comb begin
        w_size = SZ_WORD;
        if (we_i) begin
            if (funct3_i == 3'b000)      w_size = SZ_BYTE;
            else if (funct3_i == 3'b001) w_size = SZ_HALF;
        end else begin
            if (funct3_i[1:0] == 2'b00)      w_size = SZ_BYTE;
            else if (funct3_i[1:0] == 2'b01) w_size = SZ_HALF;
        end
    end

    assign w_uns = !we_i && funct3_i[2] && (w_size != SZ_WORD);

    // Lane offset, aligned down for the access width.
    always_comb begin
        case (w_size)
            SZ_BYTE: w_off = addr_i[1:0];
            SZ_HALF: w_off = {addr_i[1], 1'b0};
            default: w_off = 2'b00;
        endcase
    end

`ifdef MISALIGN_TRAP_EN
    logic r_err;
    assign w_misalign = ((w_size == SZ_HALF) && addr_i[0]) ||
                        ((w_size == SZ_WORD) && (addr_i[1:0] != 2'b00));
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)       r_err <= 1'b0;
        else if (w_accept) r_err <= w_misalign;
    end
    assign err_o = (r_state == S_RESP) && r_err;
`else
    assign w_misalign = 1'b0;
    assign err_o      = 1'b0;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_misalign)                     w_next = S_RESP;
                    else if (we_i && w_size == SZ_WORD) w_next = S_WR;
                    else                                w_next = S_RD;
                end
            end
            S_RD:    w_next = r_we ? S_MERGE : S_RESP;
            S_WR:    w_next = S_RESP;
            S_MERGE: w_next = S_RESP;
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Read data is valid during RD because the address was presented to
    // memory combinationally on the accepting edge.
    assign w_sh   = {r_off, 3'b000};
    assign w_lane = mem_data_i >> w_sh;

    always_comb begin
        w_load = w_lane;
        if (r_size == SZ_BYTE)
            w_load = r_uns ? {{(DATA_WIDTH-8){1'b0}}, w_lane[7:0]}
                           : {{(DATA_WIDTH-8){w_lane[7]}}, w_lane[7:0]};
        else if (r_size == SZ_HALF)
            w_load = r_uns ? {{(DATA_WIDTH-16){1'b0}}, w_lane[15:0]}
                           : {{(DATA_WIDTH-16){w_lane[15]}}, w_lane[15:0]};
    end

    assign w_mask   = ((r_size == SZ_BYTE) ? DATA_WIDTH'(8'hFF) : DATA_WIDTH'(16'hFFFF)) << w_sh;
    assign w_merged = (mem_data_i & ~w_mask) | ((r_wdata << w_sh) & w_mask);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
            r_we    <= 1'b0;
            r_uns   <= 1'b0;
            r_size  <= SZ_WORD;
            r_off   <= 2'b00;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_we    <= we_i;
                r_uns   <= w_uns;
                r_size  <= w_size;
                r_off   <= w_off;
                r_addr  <= addr_i[ADDR_WIDTH+1:2];
                r_wdata <= wdata_i;
            end
            if (r_state == S_RD) begin
                if (r_we) r_wdata <= w_merged;
                else      r_rdata <= w_load;
            end
        end
    end

    assign ready_o    = (r_state == S_IDLE);
    assign done_o     = (r_state == S_RESP);
    assign rdata_o    = r_rdata;
    assign mem_we_o   = (r_state == S_WR) || (r_state == S_MERGE);
    assign mem_data_o = mem_we_o ? r_wdata : '0;
    assign mem_addr_o = (r_state == S_IDLE && req_i) ? addr_i[ADDR_WIDTH+1:2] : r_addr;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        req_i = 1'b0;
    logic        we_i = 1'b0;
    logic [2:0]  funct3_i = 3'b000;
    logic [31:0] addr_i = '0;
    logic [31:0] wdata_i = '0;
    logic        ready_o, done_o, err_o, mem_we_o;
    logic [31:0] rdata_o, mem_data_o, mem_data_i;
    logic [9:0]  mem_addr_o;

    load_store_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(10)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .we_i(we_i),
        .funct3_i(funct3_i), .addr_i(addr_i), .wdata_i(wdata_i),
        .ready_o(ready_o), .done_o(done_o), .err_o(err_o), .rdata_o(rdata_o),
        .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
        .mem_data_i(mem_data_i)
    );

    always #5 clk_i = ~clk_i;

    // data_memory model: single write port, registered read
    logic [31:0] mem [0:1023];
    logic [31:0] mem_rd = '0;
    always @(posedge clk_i) begin
        if (mem_we_o) mem[mem_addr_o] <= mem_data_o;
        mem_rd <= mem[mem_addr_o];
    end
    assign mem_data_i = mem_rd;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          lat;
        int          acc;
    } resp_t;
    typedef struct {
        logic [9:0]  addr;
        logic [31:0] data;
    } wr_t;

    resp_t resp_q[$];
    wr_t   wr_q[$];

    // Monitor: compares every completion and every memory write against the queues.
    always @(negedge clk_i) begin
        if (rst_ni && done_o) begin
            if (resp_q.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                resp_t e;
                e = resp_q.pop_front();
                chk("err", {31'd0, err_o}, {31'd0, e.err});
                chk("rdata", rdata_o, e.rdata);
                chk("latency", cyc - e.acc, e.lat);
            end
        end
        if (rst_ni && mem_we_o) begin
            if (wr_q.size() == 0) begin
                chk("unexpected_write", {22'd0, mem_addr_o}, 32'hFFFF_FFFF);
            end else begin
                wr_t w;
                w = wr_q.pop_front();
                chk("wr_addr", {22'd0, mem_addr_o}, {22'd0, w.addr});
                chk("wr_data", mem_data_o, w.data);
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!ready_o && n < 50) begin
            @(negedge clk_i);
            n++;
        end
        if (!ready_o) chk("ready_timeout", 32'd0, 32'd1);
    endtask

    // Presents one request at a negedge with ready_o=1; it is accepted on the next edge.
    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input int lat, input logic e,
                         input logic [31:0] rd, input logic wr, input logic [31:0] wv,
                         input logic hold);
        resp_t r;
        wr_t   w;
        @(negedge clk_i);
        wait_ready();
        we_i = we; funct3_i = f3; addr_i = a; wdata_i = wd; req_i = 1'b1;
        r.err = e; r.rdata = rd; r.lat = lat; r.acc = cyc;
        resp_q.push_back(r);
        if (wr) begin
            w.addr = a[11:2]; w.data = wv;
            wr_q.push_back(w);
        end
        if (!hold) begin
            @(negedge clk_i);
            req_i = 1'b0;
        end
    endtask

    logic [31:0] exp_rd;
    int busy;

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        mem[1] = 32'h8081_82F3;
        mem[2] = 32'h0000_0001;
        repeat (3) @(negedge clk_i);
        chk("rst_ready_in_reset", {31'd0, ready_o}, 32'd1);
        rst_ni = 1'b1;
        @(negedge clk_i);
        chk("rst_ready", {31'd0, ready_o}, 32'd1);
        chk("rst_done", {31'd0, done_o}, 32'd0);
        chk("rst_err", {31'd0, err_o}, 32'd0);
        chk("rst_rdata", rdata_o, 32'd0);
        chk("rst_mem_we", {31'd0, mem_we_o}, 32'd0);
        chk("rst_mem_addr", {22'd0, mem_addr_o}, 32'd0);
        chk("rst_mem_data", mem_data_o, 32'd0);

        // loads: we, f3, addr, wdata, latency, err, rdata, write?, wval, hold
        issue(1'b0, 3'b010, 32'h8, 0, 2, 1'b0, 32'h0000_0001, 1'b0, 0, 1'b0);
        issue(1'b0, 3'b000, 32'h4, 0, 2, 1'b0, 32'hFFFF_FFF3, 1'b0, 0, 1'b0);
        issue(1'b0, 3'b100, 32'h7, 0, 2, 1'b0, 32'h0000_0080, 1'b0, 0, 1'b0);
        issue(1'b0, 3'b001, 32'h6, 0, 2, 1'b0, 32'hFFFF_8081, 1'b0, 0, 1'b0);
        issue(1'b0, 3'b101, 32'h4, 0, 2, 1'b0, 32'h0000_82F3, 1'b0, 0, 1'b0);
        exp_rd = 32'h0000_82F3;
        // upper address bits wrap onto word 2
        issue(1'b0, 3'b010, 32'hFFFF_F008, 0, 2, 1'b0, 32'h0000_0001, 1'b0, 0, 1'b0);
        exp_rd = 32'h0000_0001;

`ifdef MISALIGN_TRAP_EN
        issue(1'b0, 3'b010, 32'h6, 0, 1, 1'b1, exp_rd, 1'b0, 0, 1'b0);
        issue(1'b1, 3'b001, 32'h5, 32'hBEEF, 1, 1'b1, exp_rd, 1'b0, 0, 1'b0);
`else
        issue(1'b0, 3'b010, 32'h6, 0, 2, 1'b0, 32'h8081_82F3, 1'b0, 0, 1'b0);
        issue(1'b0, 3'b001, 32'h5, 0, 2, 1'b0, 32'hFFFF_82F3, 1'b0, 0, 1'b0);
        exp_rd = 32'hFFFF_82F3;
`endif

        // SB/SH read-modify-write; rdata_o must be untouched by stores
        issue(1'b1, 3'b000, 32'h5, 32'h0000_00AA, 3, 1'b0, exp_rd, 1'b1, 32'h8081_AAF3, 1'b0);
        issue(1'b0, 3'b010, 32'h4, 0, 2, 1'b0, 32'h8081_AAF3, 1'b0, 0, 1'b0);
        issue(1'b1, 3'b001, 32'h6, 32'hFFFF_1234, 3, 1'b0, 32'h8081_AAF3, 1'b1, 32'h1234_AAF3, 1'b0);
        issue(1'b0, 3'b000, 32'h6, 0, 2, 1'b0, 32'h0000_0034, 1'b0, 0, 1'b0);
        issue(1'b0, 3'b000, 32'h7, 0, 2, 1'b0, 32'h0000_0012, 1'b0, 0, 1'b0);
        issue(1'b0, 3'b001, 32'h4, 0, 2, 1'b0, 32'hFFFF_AAF3, 1'b0, 0, 1'b0);
        // store with funct3 1xx is word wide
        issue(1'b1, 3'b100, 32'hC, 32'hCAFE_F00D, 2, 1'b0, 32'hFFFF_AAF3, 1'b1, 32'hCAFE_F00D, 1'b0);
        issue(1'b0, 3'b010, 32'hC, 0, 2, 1'b0, 32'hCAFE_F00D, 1'b0, 0, 1'b0);

        // SW, then a second request held high through the busy cycles
        issue(1'b1, 3'b010, 32'h0, 32'h0000_0001, 2, 1'b0, 32'hCAFE_F00D, 1'b1, 32'h0000_0001, 1'b1);
        @(negedge clk_i);
        we_i = 1'b0; funct3_i = 3'b010; addr_i = 32'h0; wdata_i = '0;
        busy = 0;
        while (!ready_o && busy < 20) begin
            @(negedge clk_i);
            busy++;
        end
        chk("held_req_busy_cycles", busy, 2);
        begin
            resp_t r;
            r.err = 1'b0; r.rdata = 32'h0000_0001; r.lat = 2; r.acc = cyc;
            resp_q.push_back(r);
        end
        @(negedge clk_i);
        req_i = 1'b0;

        busy = 0;
        while ((resp_q.size() != 0 || !ready_o) && busy < 50) begin
            @(negedge clk_i);
            busy++;
        end
        chk("drain_resp", resp_q.size(), 0);
        chk("drain_wr", wr_q.size(), 0);
        chk("word0_after_sw", mem[0], 32'h0000_0001);

        // reset during the MERGE write of SH 0x4
        @(negedge clk_i);
        we_i = 1'b1; funct3_i = 3'b001; addr_i = 32'h4; wdata_i = 32'h0000_5555; req_i = 1'b1;
        @(posedge clk_i);
        #1 req_i = 1'b0;
        @(posedge clk_i);
        #1;
        chk("in_merge_we", {31'd0, mem_we_o}, 32'd1);
        rst_ni = 1'b0;
        #1;
        chk("abort_mem_we", {31'd0, mem_we_o}, 32'd0);
        chk("abort_ready", {31'd0, ready_o}, 32'd1);
        chk("abort_rdata", rdata_o, 32'd0);
        chk("abort_mem_data", mem_data_o, 32'd0);
        chk("abort_mem_addr", {22'd0, mem_addr_o}, 32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        chk("word1_unchanged", mem[1], 32'h1234_AAF3);
        chk("post_rst_ready", {31'd0, ready_o}, 32'd1);
        chk("post_rst_done", {31'd0, done_o}, 32'd0);
        chk("post_rst_err", {31'd0, err_o}, 32'd0);
        repeat (3) @(negedge clk_i);
        chk("post_rst_no_resp", resp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
